pueo_trig_holdoff_ctrl: RTL and testbench

//  Run/holdoff/deadtime controller for the L2 trigger. Drives holdoff_i, dead_i and logictype_i of the level-two block.

---
 rtl/pueo_trig_holdoff_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_pueo_trig_holdoff_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pueo_trig_holdoff_ctrl.sv
// -----------------------------------------------------------------------------
// pueo_trig_holdoff_ctrl
//
// Run / holdoff / deadtime controller for the L2 trigger. It accepts L2
// triggers, numbers the accepted events and tracks how many of them the
// readout has not yet finished, against the available readout buffers. It
// also applies L2 logic-type changes safely: while running, a change flushes
// the L2 DSP pipeline by holding it off for FLUSH_CYCLES ce ticks.
//
// Ports
//   clk_i, rst_i      system clock; asynchronous active-high reset
//   ce_i              sysclk_x2 clock enable; all time counts are in ce ticks
//   run_en_i          run enable (level); a rising edge starts a run
//   trig_i            L2 master trigger pulse, sampled every clk
//   evt_done_i        readout finished one event (1-clk pulse)
//   holdoff_len_i     holdoff length in ce ticks after each accepted trigger
//   logictype_wr_i    write strobe for logictype_dat_i
//   logictype_dat_i   requested L2 logic type (0=AND, 1=OR)
//   holdoff_o         to L2 holdoff_i
//   dead_o            to L2 dead_i
//   logictype_o       to L2 logictype_i
//   trig_accept_o     1-clk pulse per accepted trigger
//   evt_num_o         number of the last accepted event
//   outstanding_o     events not yet finished by the readout
//   deadtime_o        ce ticks with holdoff_o|dead_o high while running (saturating)
//   err_cnt_o         protocol errors (saturating)
// -----------------------------------------------------------------------------
module pueo_trig_holdoff_ctrl #(
   parameter  int MAX_OUTSTANDING = 32,
   parameter  int FLUSH_CYCLES    = 4,
   parameter  int EVT_W           = 32,
   localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ce_i,
   input  logic             run_en_i,
   input  logic             trig_i,
   input  logic             evt_done_i,
   input  logic [15:0]      holdoff_len_i,
   input  logic             logictype_wr_i,
   input  logic             logictype_dat_i,
   output logic             holdoff_o,
   output logic             dead_o,
   output logic             logictype_o,
   output logic             trig_accept_o,
   output logic [EVT_W-1:0] evt_num_o,
   output logic [OUT_W-1:0] outstanding_o,
   output logic [31:0]      deadtime_o,
   output logic [15:0]      err_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_HOLDOFF,
      ST_RECONFIG
   } state_t;

   localparam logic [15:0]      FLUSH_LEN = 16'(FLUSH_CYCLES);
   localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

   state_t           state_q, state_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             logictype_q, logictype_d;
   logic             pend_q, pend_d;
   logic             pend_dat_q, pend_dat_d;
   logic             run_en_q;
   logic             holdoff_q, holdoff_d;
   logic             dead_q, dead_d;
   logic             trig_accept_q;
   logic [EVT_W-1:0] evt_num_q, evt_num_d;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic [31:0]      deadtime_q, deadtime_d;
   logic [15:0]      err_cnt_q, err_cnt_d;

   logic             run_rise;
   logic             accept;
   logic             trig_err;
   logic             done_err;
   logic             done_ok;
   logic             wr_pend;
   logic             wr_dat;
   logic [16:0]      err_sum;

   // ---------------------------------------------------------------- datapath
   always_comb begin
      run_rise = run_en_i & ~run_en_q;
      // A run_en drop wins over a trigger in the same clk.
      accept   = (state_q == ST_ARMED) & run_en_i & trig_i & ~dead_q;
      // In IDLE holdoff_q and dead_q are both high, so this covers IDLE too.
      trig_err = trig_i & (holdoff_q | dead_q);
      done_err = evt_done_i & (outstanding_q == '0);
      done_ok  = evt_done_i & ~done_err;

      // An accept and a done in the same clk cancel out.
      outstanding_d = outstanding_q;
      if (accept && !done_ok)      outstanding_d = outstanding_q + 1'b1;
      else if (!accept && done_ok) outstanding_d = outstanding_q - 1'b1;

      err_sum   = {1'b0, err_cnt_q} + 17'(trig_err) + 17'(done_err);
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

      evt_num_d  = evt_num_q;
      deadtime_d = deadtime_q;
      if (state_q == ST_IDLE) begin
         if (run_rise) begin
            evt_num_d  = '0;
            deadtime_d = '0;
         end
      end else begin
         if (accept) evt_num_d = evt_num_q + 1'b1;
         if (ce_i && (holdoff_q || dead_q) && (deadtime_q != 32'hFFFF_FFFF))
            deadtime_d = deadtime_q + 32'd1;
      end
   end

   // --------------------------------------------------------- next-state logic
   always_comb begin
      // NOTE: every signal assigned here gets its default first, so no path
      // through the case statements can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      logictype_d = logictype_q;
      pend_d      = pend_q;
      pend_dat_d  = pend_dat_q;

      // A write in this clk supersedes a write already pending.
      wr_pend = logictype_wr_i | pend_q;
      wr_dat  = logictype_wr_i ? logictype_dat_i : pend_dat_q;

      if ((state_q != ST_IDLE) && !run_en_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         pend_d  = 1'b0;
         if (wr_pend) logictype_d = wr_dat;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (logictype_wr_i) logictype_d = logictype_dat_i;
               if (run_rise)       state_d     = ST_ARMED;
            end
            ST_ARMED: begin
               if (accept) begin
                  cnt_d   = (holdoff_len_i == '0) ? 16'd1 : holdoff_len_i;
                  state_d = ST_HOLDOFF;
                  if (logictype_wr_i) begin
                     pend_d     = 1'b1;
                     pend_dat_d = logictype_dat_i;
                  end
               end else if (logictype_wr_i) begin
                  logictype_d = logictype_dat_i;
                  cnt_d       = FLUSH_LEN;
                  state_d     = ST_RECONFIG;
               end
            end
            ST_HOLDOFF: begin
               if (logictype_wr_i) begin
                  pend_d     = 1'b1;
                  pend_dat_d = logictype_dat_i;
               end
               if (ce_i) begin
                  if (cnt_q <= 16'd1) begin
                     if (wr_pend) begin
                        logictype_d = wr_dat;
                        pend_d      = 1'b0;
                        cnt_d       = FLUSH_LEN;
                        state_d     = ST_RECONFIG;
                     end else begin
                        cnt_d   = '0;
                        state_d = ST_ARMED;
                     end
                  end else begin
                     cnt_d = cnt_q - 16'd1;
                  end
               end
            end
            ST_RECONFIG: begin
               if (logictype_wr_i) begin
                  logictype_d = logictype_dat_i;
                  cnt_d       = FLUSH_LEN;
               end else if (ce_i) begin
                  if (cnt_q <= 16'd1) begin
                     cnt_d   = '0;
                     state_d = ST_ARMED;
                  end else begin
                     cnt_d = cnt_q - 16'd1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are registered from the next state so they line up with it.
      holdoff_d = (state_d != ST_ARMED);
      dead_d    = (state_d == ST_IDLE) || (outstanding_d == OUT_MAX);
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         logictype_q   <= 1'b0;
         pend_q        <= 1'b0;
         pend_dat_q    <= 1'b0;
         run_en_q      <= 1'b0;
         holdoff_q     <= 1'b1;
         dead_q        <= 1'b1;
         trig_accept_q <= 1'b0;
         evt_num_q     <= '0;
         outstanding_q <= '0;
         deadtime_q    <= '0;
         err_cnt_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         logictype_q   <= logictype_d;
         pend_q        <= pend_d;
         pend_dat_q    <= pend_dat_d;
         run_en_q      <= run_en_i;
         holdoff_q     <= holdoff_d;
         dead_q        <= dead_d;
         trig_accept_q <= accept;
         evt_num_q     <= evt_num_d;
         outstanding_q <= outstanding_d;
         deadtime_q    <= deadtime_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign holdoff_o     = holdoff_q;
   assign dead_o        = dead_q;
   assign logictype_o   = logictype_q;
   assign trig_accept_o = trig_accept_q;
   assign evt_num_o     = evt_num_q;
   assign outstanding_o = outstanding_q;
   assign deadtime_o    = deadtime_q;
   assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_pueo_trig_holdoff_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pueo_trig_holdoff_ctrl
//
// Directed scenarios followed by a randomized phase. A behavioural model
// describes the controller as "running or not" plus remaining holdoff and
// flush tick budgets and a list of deferred logic-type writes; every clk all
// outputs are compared with it, and the directed scenarios add absolute
// expectations on top.
// -----------------------------------------------------------------------------
module tb_pueo_trig_holdoff_ctrl;

   localparam int MAX_OUT = 32;
   localparam int FLUSH   = 4;
   localparam int OUT_W   = $clog2(MAX_OUT + 1);

   logic             clk;
   logic             rst;
   logic             ce;
   logic             run_en;
   logic             trig;
   logic             done;
   logic [15:0]      hlen;
   logic             wr;
   logic             dat;
   logic             holdoff_o;
   logic             dead_o;
   logic             logictype_o;
   logic             trig_accept_o;
   logic [31:0]      evt_num_o;
   logic [OUT_W-1:0] outstanding_o;
   logic [31:0]      deadtime_o;
   logic [15:0]      err_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   pueo_trig_holdoff_ctrl #(
      .MAX_OUTSTANDING(MAX_OUT),
      .FLUSH_CYCLES   (FLUSH),
      .EVT_W          (32)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .ce_i           (ce),
      .run_en_i       (run_en),
      .trig_i         (trig),
      .evt_done_i     (done),
      .holdoff_len_i  (hlen),
      .logictype_wr_i (wr),
      .logictype_dat_i(dat),
      .holdoff_o      (holdoff_o),
      .dead_o         (dead_o),
      .logictype_o    (logictype_o),
      .trig_accept_o  (trig_accept_o),
      .evt_num_o      (evt_num_o),
      .outstanding_o  (outstanding_o),
      .deadtime_o     (deadtime_o),
      .err_cnt_o      (err_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------ model state
   bit          m_running;
   int          m_hold_left;
   int          m_flush_left;
   bit          m_lt;
   bit          m_acc;
   logic [31:0] m_evt;
   int          m_outst;
   logic [31:0] m_dtime;
   int          m_err;
   bit          m_prev_run;
   bit          m_pend[$];

   function automatic bit m_holdoff();
      return !(m_running && m_hold_left == 0 && m_flush_left == 0);
   endfunction

   function automatic bit m_dead();
      return !m_running || (m_outst == MAX_OUT);
   endfunction

   task automatic model_reset();
      m_running    = 0;
      m_hold_left  = 0;
      m_flush_left = 0;
      m_lt         = 0;
      m_acc        = 0;
      m_evt        = '0;
      m_outst      = 0;
      m_dtime      = '0;
      m_err        = 0;
      m_prev_run   = 0;
      m_pend.delete();
   endtask

   // Advances the model by one clk using the inputs presented at this edge.
   task automatic model_step();
      bit hold_now;
      bit dead_now;
      bit acc;
      bit t_err;
      bit d_err;
      if (rst) begin
         model_reset();
         return;
      end
      hold_now = m_holdoff();
      dead_now = m_dead();
      acc      = !hold_now && run_en && trig && !dead_now;
      t_err    = trig && (hold_now || dead_now);
      d_err    = done && (m_outst == 0);

      if (m_running && (hold_now || dead_now) && ce && m_dtime != 32'hFFFF_FFFF)
         m_dtime = m_dtime + 1;
      m_err = m_err + int'(t_err) + int'(d_err);
      if (m_err > 65535) m_err = 65535;
      m_outst = m_outst + int'(acc) - int'(done && !d_err);
      m_acc = acc;

      if (!m_running) begin
         if (wr) m_lt = dat;
         if (run_en && !m_prev_run) begin
            m_running = 1;
            m_evt     = '0;
            m_dtime   = '0;
         end
      end else if (!run_en) begin
         m_running = 0;
         if (wr) m_lt = dat;
         else if (m_pend.size() > 0) m_lt = m_pend[$];
         m_pend.delete();
         m_hold_left  = 0;
         m_flush_left = 0;
      end else if (!hold_now) begin
         if (acc) begin
            m_evt       = m_evt + 1;
            m_hold_left = (hlen == 0) ? 1 : int'(hlen);
            if (wr) m_pend.push_back(dat);
         end else if (wr) begin
            m_lt         = dat;
            m_flush_left = FLUSH;
         end
      end else if (m_hold_left > 0) begin
         if (wr) m_pend.push_back(dat);
         if (ce) begin
            m_hold_left--;
            if (m_hold_left == 0 && m_pend.size() > 0) begin
               m_lt         = m_pend[$];
               m_flush_left = FLUSH;
               m_pend.delete();
            end
         end
      end else begin
         if (wr) m_flush_left = FLUSH;
         if (wr) m_lt = dat;
         else if (ce) m_flush_left--;
      end
      m_prev_run = run_en;
   endtask

   task automatic compare_all();
      check("trig_accept", trig_accept_o, m_acc);
      check("evt_num", evt_num_o, m_evt);
      check("outstanding", outstanding_o, m_outst);
      check("holdoff", holdoff_o, m_holdoff());
      check("dead", dead_o, m_dead());
      check("logictype", logictype_o, m_lt);
      check("deadtime", deadtime_o, m_dtime);
      check("err_cnt", err_cnt_o, m_err);
   endtask

   // One clk: inputs are already set; model advances at the edge, outputs
   // are compared 1 ns later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      trig = 0;
      done = 0;
      wr   = 0;
      ce   = 1'($urandom);
   endtask

   task automatic wait_armed();
      for (int i = 0; i < 1000; i++) begin
         if (!holdoff_o) return;
         idle_inputs();
         tick();
      end
      check("wait_armed_timeout", 0, 1);
   endtask

   // Counts ce ticks that holdoff_o spends high, starting now.
   task automatic measure_holdoff(output int n);
      n = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!holdoff_o) return;
         idle_inputs();
         tick();
         if (ce) n++;
      end
      check("holdoff_timeout", 0, 1);
   endtask

   initial begin
      int n;
      int chg_at;
      int guard;
      logic [31:0] saved_evt;
      logic [15:0] saved_err;
      logic [OUT_W-1:0] saved_out;
      logic lt_before;

      rst = 1; ce = 0; run_en = 0; trig = 0; done = 0; hlen = 16'd10; wr = 0; dat = 0;
      model_reset();
      repeat (3) tick();
      check("rst_holdoff", holdoff_o, 1);
      check("rst_dead", dead_o, 1);
      check("rst_evt", evt_num_o, 0);
      rst = 0;

      // 1: single trigger, 10-tick holdoff
      run_en = 1;
      idle_inputs();
      tick();
      check("t1_armed", holdoff_o, 0);
      trig = 1;
      tick();
      trig = 0;
      check("t1_accept", trig_accept_o, 1);
      check("t1_evt", evt_num_o, 1);
      check("t1_out", outstanding_o, 1);
      measure_holdoff(n);
      check("t1_holdoff_ticks", n, 10);

      // 2: fill all readout buffers
      hlen  = 16'd1;
      guard = 0;
      while (outstanding_o < OUT_W'(MAX_OUT) && guard < 2000) begin
         idle_inputs();
         trig = !holdoff_o && !dead_o;
         tick();
         guard++;
      end
      trig = 0;
      check("t2_dead_full", dead_o, 1);
      check("t2_evt_full", evt_num_o, 32);
      wait_armed();
      trig = 1;
      tick();
      trig = 0;
      check("t2_err", err_cnt_o, 1);
      check("t2_evt_stays", evt_num_o, 32);
      done = 1;
      tick();
      done = 0;
      check("t2_dead_clear", dead_o, 0);
      check("t2_out", outstanding_o, 31);

      // 3: logic-type writes during holdoff are deferred, last one wins
      wait_armed();
      wr = 1; dat = 1;
      tick();
      wr = 0;
      check("t3_lt_direct", logictype_o, 1);
      wait_armed();
      hlen = 16'd10;
      trig = 1;
      tick();
      trig = 0;
      n = 0;
      chg_at = -1;
      for (int i = 0; i < 1000; i++) begin
         if (!holdoff_o) break;
         idle_inputs();
         wr  = (i < 2);
         dat = (i == 0);
         lt_before = logictype_o;
         tick();
         if (ce) n++;
         if (logictype_o != lt_before) chg_at = n;
      end
      wr = 0;
      check("t3_lt_change_tick", chg_at, 10);
      check("t3_total_ticks", n, 14);
      check("t3_lt_final", logictype_o, 0);

      // 4: simultaneous accept and done; done with nothing outstanding
      guard = 0;
      while (outstanding_o > 3 && guard < 200) begin
         idle_inputs();
         done = 1;
         tick();
         guard++;
      end
      done = 0;
      wait_armed();
      saved_evt = evt_num_o;
      trig = 1; done = 1;
      tick();
      trig = 0; done = 0;
      check("t4_out_same", outstanding_o, 3);
      check("t4_evt_inc", evt_num_o, saved_evt + 1);
      guard = 0;
      while (outstanding_o != 0 && guard < 200) begin
         idle_inputs();
         done = 1;
         tick();
         guard++;
      end
      saved_err = err_cnt_o;
      idle_inputs();
      done = 1;
      tick();
      done = 0;
      check("t4_done_err", err_cnt_o, saved_err + 1);
      check("t4_out_zero", outstanding_o, 0);

      // 5: drop run_en mid-holdoff, then restart
      wait_armed();
      trig = 1;
      tick();
      idle_inputs();
      tick();
      tick();
      run_en = 0;
      tick();
      check("t5_idle_holdoff", holdoff_o, 1);
      check("t5_idle_dead", dead_o, 1);
      saved_out = outstanding_o;
      run_en = 1;
      tick();
      check("t5_evt_clr", evt_num_o, 0);
      check("t5_dtime_clr", deadtime_o, 0);
      check("t5_out_kept", outstanding_o, saved_out);

      // 6: zero holdoff length, then async reset mid-reconfig
      hlen = 16'd0;
      trig = 1;
      tick();
      trig = 0;
      measure_holdoff(n);
      check("t6_min_holdoff", n, 1);
      wr = 1; dat = 1;
      tick();
      wr = 0;
      tick();
      rst = 1;
      #1;
      check("t6_rst_holdoff", holdoff_o, 1);
      check("t6_rst_dead", dead_o, 1);
      check("t6_rst_lt", logictype_o, 0);
      check("t6_rst_acc", trig_accept_o, 0);
      check("t6_rst_evt", evt_num_o, 0);
      check("t6_rst_out", outstanding_o, 0);
      check("t6_rst_dtime", deadtime_o, 0);
      check("t6_rst_err", err_cnt_o, 0);
      model_reset();
      tick();
      tick();
      rst = 0;

      // Randomized phase
      run_en = 1;
      for (int i = 0; i < 3000; i++) begin
         ce   = 1'($urandom);
         trig = ($urandom_range(0, 3) == 0);
         done = ($urandom_range(0, 4) == 0);
         wr   = ($urandom_range(0, 9) == 0);
         dat  = 1'($urandom);
         hlen = 16'($urandom_range(0, 6));
         if (run_en && $urandom_range(0, 99) == 0) run_en = 0;
         else if (!run_en && $urandom_range(0, 9) == 0) run_en = 1;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
